// File: rtl/hwpe_tiled_ctrl_fsm_pkg.sv
// Shared types and parameter defaults for the tiled HWPE controller.
// Imported by the top-level FSM and the per-stream address accumulator.
package hwpe_tiled_ctrl_package;

  localparam int unsigned NB_SOURCE_DEF = 1;
  localparam int unsigned NB_SINK_DEF   = 1;
  localparam int unsigned LEN_W_DEF     = 16;
  localparam int unsigned TILE_W_DEF    = 8;
  localparam int unsigned ADDR_W_DEF    = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT      = 3'd1,
    ST_COMPUTE   = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_UPDATE    = 3'd4,
    ST_TERMINATE = 3'd5
  } tiled_fsm_state_t;

endpackage

// File: rtl/hwpe_tiled_ctrl_fsm_addr_acc.sv
// Per-stream tile address generator: latched base plus an offset that
// advances by a latched stride at each tile update (wraps modulo 2^ADDR_W).
module hwpe_tile_addr_acc
  import hwpe_tiled_ctrl_package::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] offs_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      base_q   <= '0;
      stride_q <= '0;
      offs_q   <= '0;
    end else if (load_i) begin
      base_q   <= base_i;
      stride_q <= stride_i;
      offs_q   <= '0;
    end else if (step_i) begin
      offs_q <= offs_q + stride_q;
    end
  end

  assign addr_o = base_q + offs_q;

endmodule

// File: rtl/hwpe_tiled_ctrl_fsm.sv
// Tiled HWPE controller: sequences nb_tiles jobs of len elements through
// the source/sink streamers and the engine, with per-tile events and abort.
module hwpe_tiled_ctrl_fsm
  import hwpe_tiled_ctrl_package::*;
#(
  parameter int unsigned NB_SOURCE = NB_SOURCE_DEF,
  parameter int unsigned NB_SINK   = NB_SINK_DEF,
  parameter int unsigned LEN_W     = LEN_W_DEF,
  parameter int unsigned TILE_W    = TILE_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic [LEN_W-1:0]            len_i,
  input  logic [TILE_W-1:0]           nb_tiles_i,
  input  logic [NB_SOURCE*ADDR_W-1:0] src_base_i,
  input  logic [NB_SINK*ADDR_W-1:0]   snk_base_i,
  input  logic [NB_SOURCE*ADDR_W-1:0] src_stride_i,
  input  logic [NB_SINK*ADDR_W-1:0]   snk_stride_i,
  input  logic [NB_SOURCE-1:0]        src_ready_start_i,
  input  logic [NB_SINK-1:0]          snk_ready_start_i,
  output logic [NB_SOURCE-1:0]        src_req_start_o,
  output logic [NB_SINK-1:0]          snk_req_start_o,
  output logic [NB_SOURCE*ADDR_W-1:0] src_addr_o,
  output logic [NB_SINK*ADDR_W-1:0]   snk_addr_o,
  output logic [LEN_W-1:0]            trans_size_o,
  output logic                        eng_start_o,
  output logic                        eng_clear_o,
  output logic                        eng_enable_o,
  input  logic [LEN_W-1:0]            eng_cnt_i,
  output logic                        evt_o,
  output logic                        done_o,
  output logic                        aborted_o,
  output logic                        busy_o,
  output logic [TILE_W-1:0]           tile_idx_o
);

  tiled_fsm_state_t state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [TILE_W-1:0] nb_tiles_q;
  logic [TILE_W-1:0] tile_idx_q;
  logic              abort_q;

  logic all_src_rdy, all_snk_rdy;
  logic abort_hit, last_tile;
  logic req_start, tile_evt, load, step;

  assign all_src_rdy = &src_ready_start_i;
  assign all_snk_rdy = &snk_ready_start_i;
  assign last_tile   = (tile_idx_q == nb_tiles_q - TILE_W'(1));

  // Abort only matters while a job is in flight; it masks every pulse in that cycle.
  assign abort_hit = abort_i && (state_q inside {ST_WAIT, ST_COMPUTE, ST_DRAIN, ST_UPDATE});
  assign req_start = (state_q == ST_WAIT)  && all_src_rdy && all_snk_rdy && !abort_i;
  assign tile_evt  = (state_q == ST_DRAIN) && all_snk_rdy && !abort_i;
  assign load      = (state_q == ST_IDLE)  && start_i;
  assign step      = (state_q == ST_UPDATE) && !abort_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i == '0 || nb_tiles_i == '0) state_d = ST_TERMINATE;
          else                                 state_d = ST_WAIT;
        end
      end
      ST_WAIT:      if (req_start) state_d = ST_COMPUTE;
      ST_COMPUTE:   if (eng_cnt_i == len_q) state_d = ST_DRAIN;
      ST_DRAIN:     if (tile_evt) state_d = last_tile ? ST_TERMINATE : ST_UPDATE;
      ST_UPDATE:    state_d = ST_WAIT;
      ST_TERMINATE: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (abort_hit) state_d = ST_TERMINATE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      nb_tiles_q <= '0;
      tile_idx_q <= '0;
      abort_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        len_q      <= len_i;
        nb_tiles_q <= nb_tiles_i;
        tile_idx_q <= '0;
        abort_q    <= 1'b0;
      end
      if (step)      tile_idx_q <= tile_idx_q + TILE_W'(1);
      if (abort_hit) abort_q    <= 1'b1;
    end
  end

  for (genvar i = 0; i < NB_SOURCE; i++) begin : g_src
    hwpe_tile_addr_acc #(.ADDR_W(ADDR_W)) u_acc (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (clear_i),
      .load_i   (load),
      .step_i   (step),
      .base_i   (src_base_i[i*ADDR_W +: ADDR_W]),
      .stride_i (src_stride_i[i*ADDR_W +: ADDR_W]),
      .addr_o   (src_addr_o[i*ADDR_W +: ADDR_W])
    );
  end

  for (genvar i = 0; i < NB_SINK; i++) begin : g_snk
    hwpe_tile_addr_acc #(.ADDR_W(ADDR_W)) u_acc (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (clear_i),
      .load_i   (load),
      .step_i   (step),
      .base_i   (snk_base_i[i*ADDR_W +: ADDR_W]),
      .stride_i (snk_stride_i[i*ADDR_W +: ADDR_W]),
      .addr_o   (snk_addr_o[i*ADDR_W +: ADDR_W])
    );
  end

  assign src_req_start_o = {NB_SOURCE{req_start}};
  assign snk_req_start_o = {NB_SINK{req_start}};
  assign eng_start_o     = req_start;
  assign eng_clear_o     = (state_q == ST_IDLE);
  assign eng_enable_o    = (state_q == ST_COMPUTE) || (state_q == ST_DRAIN);
  assign evt_o           = tile_evt;
  assign done_o          = (state_q == ST_TERMINATE);
  assign aborted_o       = (state_q == ST_TERMINATE) && abort_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign trans_size_o    = len_q;
  assign tile_idx_o      = tile_idx_q;

endmodule
